// File: rtl/inst_buffer_pkg.sv
// Shared definitions for the instruction buffer between fetch and dispatch:
// superscalar width, buffer depth, the instruction packet and index helpers.
package inst_buffer_pkg;

    localparam int N           = 3;
    localparam int IBUFF_DEPTH = 8;
    localparam int DEPTH       = IBUFF_DEPTH;
    localparam int ADDR_W      = 32;
    localparam int INST_W      = 32;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int NUM_W = $clog2(N + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } inst_packet_t;

    // Circular index: base + off, wrapping modulo DEPTH (DEPTH is a power of two).
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned      off);
        return base + PTR_W'(off);
    endfunction

endpackage

// File: rtl/inst_buffer_if.sv
// Fetch/dispatch bundle of the instruction buffer; master is the pipeline
// control side, slave is the buffer itself.
interface inst_buffer_if;
    import inst_buffer_pkg::*;

    logic                     flush;
    inst_packet_t [N-1:0]     in_insts;
    logic [NUM_W-1:0]         in_num;
    logic [NUM_W-1:0]         dispatch_num;
    inst_packet_t [N-1:0]     out_insts;
    logic [NUM_W-1:0]         out_num;
    logic                     ibuff_open;
    logic [CNT_W-1:0]         count;
    logic                     overflow;

    modport master (
        output flush, in_insts, in_num, dispatch_num,
        input  out_insts, out_num, ibuff_open, count, overflow
    );

    modport slave (
        input  flush, in_insts, in_num, dispatch_num,
        output out_insts, out_num, ibuff_open, count, overflow
    );

endinterface

// File: rtl/inst_buffer.sv
// Multi-ported circular instruction FIFO: up to N pushes from fetch and up to
// N pops by dispatch per cycle, with flow control back to fetch and flush.
module inst_buffer
    import inst_buffer_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    inst_buffer_if.slave  bus
);

    typedef logic [CNT_W:0] wide_t;

    inst_packet_t       entries [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count_q;
    logic               overflow_q;

    logic [NUM_W-1:0]   out_num_w;
    logic [NUM_W-1:0]   pop_num;
    logic [NUM_W-1:0]   push_num;
    wide_t              room;
    logic               ovf_now;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        out_num_w = NUM_W'(count_q);
        if (count_q >= CNT_W'(N)) begin
            out_num_w = NUM_W'(N);
        end

        // A pop beyond what is visible is clamped; only cycle-start entries leave.
        pop_num = bus.dispatch_num;
        if (bus.dispatch_num > out_num_w) begin
            pop_num = out_num_w;
        end

        // Slots available to this cycle's pushes, counting the ones freed by the pop.
        room     = wide_t'(DEPTH) - wide_t'(count_q) + wide_t'(pop_num);
        ovf_now  = wide_t'(bus.in_num) > room;
        push_num = bus.in_num;
        if (ovf_now) begin
            push_num = NUM_W'(room);
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; blocking here would make pop/push order matter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head       <= '0;
            tail       <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            // NOTE: the storage array is reset too so out_insts never carries
            // X after power-up; it is small enough that the reset fan-out is fine.
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (bus.flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (NUM_W'(i) < push_num) begin
                    entries[wrap_idx(tail, i)] <= bus.in_insts[i];
                end
            end
            tail    <= tail + PTR_W'(push_num);
            head    <= head + PTR_W'(pop_num);
            count_q <= count_q + CNT_W'(push_num) - CNT_W'(pop_num);
            if (ovf_now) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_comb begin
        bus.out_insts = '0;
        for (int i = 0; i < N; i++) begin
            if (NUM_W'(i) < out_num_w) begin
                bus.out_insts[i] = entries[wrap_idx(head, i)];
            end
        end
    end

    // Fetch registers its batch a cycle after sampling this, so the batch
    // already on in_num is counted as occupied.
    assign bus.ibuff_open = (wide_t'(count_q) + wide_t'(bus.in_num) + wide_t'(N))
                            <= wide_t'(DEPTH);
    assign bus.out_num    = out_num_w;
    assign bus.count      = count_q;
    assign bus.overflow   = overflow_q;

    a_no_underflow: assert property (
        @(posedge clock) disable iff (!reset)
        !bus.flush |-> (bus.dispatch_num <= out_num_w)
    );

endmodule
